// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm ring/snooze/timeout controller driven by BCD time compare
module alarm_controller #(
    parameter int RING_TIMEOUT   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        one_second,
    input  logic [15:0] cur_time,
    input  logic [15:0] alarm_time,
    input  logic        alarm_enable,
    input  logic        stop_alarm,
    input  logic        snooze,
    output logic        sound_alarm,
    output logic        snoozing,
    output logic [3:0]  snooze_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [15:0] RING_LAST = 16'(RING_TIMEOUT - 1);
    localparam logic [15:0] SNZ_LAST  = 16'(SNOOZE_SECONDS - 1);
    localparam logic [3:0]  SNZ_MAX   = 4'(MAX_SNOOZE);

    state_t      state, state_next;
    logic [15:0] ring_cnt, ring_cnt_next;
    logic [15:0] snz_cnt, snz_cnt_next;
    logic [3:0]  count_next;
    logic        stop_d, snz_d;
    logic        match, stop_edge, snz_edge;

    assign match     = alarm_enable & (cur_time == alarm_time);
    assign stop_edge = stop_alarm & ~stop_d;
    assign snz_edge  = snooze & ~snz_d;

    always_comb begin
        state_next    = state;
        ring_cnt_next = ring_cnt;
        snz_cnt_next  = snz_cnt;
        count_next    = snooze_count;
        if (!alarm_enable) begin
            state_next    = IDLE;
            ring_cnt_next = '0;
            snz_cnt_next  = '0;
            count_next    = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (match) begin
                        state_next    = RINGING;
                        ring_cnt_next = '0;
                        count_next    = '0;
                    end
                end
                RINGING: begin
                    if (stop_edge) begin
                        state_next = DONE;
                    end else if (snz_edge) begin
                        // once the snooze allowance is used up, the button acts as stop
                        if (snooze_count < SNZ_MAX) begin
                            state_next   = SNOOZE;
                            snz_cnt_next = '0;
                            count_next   = snooze_count + 4'd1;
                        end else begin
                            state_next = DONE;
                        end
                    end else if (one_second) begin
                        if (ring_cnt == RING_LAST) begin
                            state_next = DONE;
                        end else begin
                            ring_cnt_next = ring_cnt + 16'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_edge) begin
                        state_next = DONE;
                    end else if (one_second) begin
                        if (snz_cnt == SNZ_LAST) begin
                            state_next    = RINGING;
                            ring_cnt_next = '0;
                        end else begin
                            snz_cnt_next = snz_cnt + 16'd1;
                        end
                    end
                end
                DONE: begin
                    // hold off until the alarm minute passes so it fires only once
                    if (!match) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            ring_cnt     <= '0;
            snz_cnt      <= '0;
            snooze_count <= '0;
            stop_d       <= 1'b1;
            snz_d        <= 1'b1;
            sound_alarm  <= 1'b0;
            snoozing     <= 1'b0;
        end else begin
            state        <= state_next;
            ring_cnt     <= ring_cnt_next;
            snz_cnt      <= snz_cnt_next;
            snooze_count <= count_next;
            stop_d       <= stop_alarm;
            snz_d        <= snooze;
            sound_alarm  <= (state_next == RINGING);
            snoozing     <= (state_next == SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - scoreboard bench for alarm_controller with directed and random stimulus
module tb_alarm_controller;

    localparam int RING_T = 4;
    localparam int SNZ_T  = 5;
    localparam int MAX_S  = 2;
    localparam logic [15:0] ALARM = 16'h0730;

    logic        clk = 1'b0;
    logic        reset, one_second, alarm_enable, stop_alarm, snooze;
    logic [15:0] cur_time, alarm_time;
    logic        sound_alarm, snoozing;
    logic [3:0]  snooze_count;

    alarm_controller #(
        .RING_TIMEOUT(RING_T), .SNOOZE_SECONDS(SNZ_T), .MAX_SNOOZE(MAX_S)
    ) dut (
        .clk(clk), .reset(reset), .one_second(one_second), .cur_time(cur_time),
        .alarm_time(alarm_time), .alarm_enable(alarm_enable), .stop_alarm(stop_alarm),
        .snooze(snooze), .sound_alarm(sound_alarm), .snoozing(snoozing),
        .snooze_count(snooze_count)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    logic [5:0] exp_q[$];
    string name_q[$];

    // Reference model: phases of an alarm event and elapsed seconds in each.
    localparam int OFF = 0, RING = 1, PAUSE = 2, FIRED = 3;
    int phase = OFF;
    int rung = 0, quiet = 0, used = 0;
    bit prev_stop = 1, prev_snz = 1;

    task automatic model(input bit rst, input bit en, input logic [15:0] cur,
                         input bit stp, input bit snz, input bit tick);
        bit se, ze, hit;
        if (!rst) begin
            phase = OFF; rung = 0; quiet = 0; used = 0;
            prev_stop = 1; prev_snz = 1;
            return;
        end
        se = stp && !prev_stop;
        ze = snz && !prev_snz;
        prev_stop = stp;
        prev_snz  = snz;
        hit = en && (cur == ALARM);
        if (!en) begin
            phase = OFF; rung = 0; quiet = 0; used = 0;
            return;
        end
        case (phase)
            OFF: if (hit) begin phase = RING; rung = 0; used = 0; end
            RING: begin
                if (se) phase = FIRED;
                else if (ze) begin
                    if (used < MAX_S) begin phase = PAUSE; quiet = 0; used++; end
                    else phase = FIRED;
                end else if (tick) begin
                    rung++;
                    if (rung == RING_T) phase = FIRED;
                end
            end
            PAUSE: begin
                if (se) phase = FIRED;
                else if (tick) begin
                    quiet++;
                    if (quiet == SNZ_T) begin phase = RING; rung = 0; end
                end
            end
            default: if (!hit) phase = OFF;
        endcase
    endtask

    task automatic step(input string nm, input bit rst, input bit en, input logic [15:0] cur,
                        input bit stp, input bit snz, input bit tick);
        @(negedge clk);
        reset = rst; alarm_enable = en; cur_time = cur;
        stop_alarm = stp; snooze = snz; one_second = tick;
        model(rst, en, cur, stp, snz, tick);
        exp_q.push_back({phase == RING, phase == PAUSE, 4'(used)});
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        logic [5:0] e, a;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                nm = name_q.pop_front();
                a = {sound_alarm, snoozing, snooze_count};
                compared++;
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL %s t=%0t: got sound=%b snoozing=%b count=%0d, expected sound=%b snoozing=%b count=%0d",
                             nm, $time, a[5], a[4], a[3:0], e[5], e[4], e[3:0]);
                end
            end
        end
    end

    initial begin : driver
        bit en, stp, snz, tk, rs;
        logic [15:0] cur;
        logic [15:0] times[3];
        times[0] = 16'h0729; times[1] = 16'h0730; times[2] = 16'h0731;
        alarm_time = ALARM;
        reset = 1'b0; alarm_enable = 1'b0; cur_time = 16'h0729;
        stop_alarm = 1'b0; snooze = 1'b0; one_second = 1'b0;
        repeat (3) step("reset", 0, 0, 16'h0729, 0, 0, 0);
        // 1: alarm fires when time reaches alarm minute
        repeat (3) step("pre_alarm", 1, 1, 16'h0729, 0, 0, 1);
        repeat (2) step("ring_start", 1, 1, 16'h0730, 0, 0, 0);
        // 2: stop, held minute never re-rings, next minute goes idle
        step("stop", 1, 1, 16'h0730, 1, 0, 0);
        step("stop_rel", 1, 1, 16'h0730, 0, 0, 0);
        repeat (100) step("done_hold", 1, 1, 16'h0730, 0, 0, 1);
        repeat (2) step("to_idle", 1, 1, 16'h0731, 0, 0, 0);
        // 3: timeout after RING_T ticks
        step("ring2", 1, 1, 16'h0730, 0, 0, 0);
        for (int i = 0; i < RING_T; i++) begin
            step("timeout_tick", 1, 1, 16'h0730, 0, 0, 1);
            step("timeout_gap", 1, 1, 16'h0730, 0, 0, 0);
        end
        repeat (5) step("no_rering", 1, 1, 16'h0730, 0, 0, 1);
        step("idle2", 1, 1, 16'h0731, 0, 0, 0);
        // 4/5: snooze, expiry, snooze limit
        step("ring3", 1, 1, 16'h0730, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step("snz_press", 1, 1, 16'h0730, 0, 1, 1);
            step("snz_rel", 1, 1, 16'h0730, 0, 0, 0);
            if (k < 2) repeat (SNZ_T) step("snz_tick", 1, 1, 16'h0730, 0, 0, 1);
        end
        step("idle3", 1, 1, 16'h0731, 0, 0, 0);
        // stop and snooze together
        step("ring4", 1, 1, 16'h0730, 0, 0, 0);
        step("stop_snz_same", 1, 1, 16'h0730, 1, 1, 1);
        step("rel4", 1, 1, 16'h0731, 0, 0, 0);
        // 6: enable drop while ringing
        step("ring5", 1, 1, 16'h0730, 0, 0, 0);
        step("en_drop", 1, 0, 16'h0730, 0, 0, 0);
        step("ring6", 1, 1, 16'h0730, 0, 0, 0);
        step("snz6", 1, 1, 16'h0730, 0, 1, 0);
        step("rst_mid_snz", 0, 1, 16'h0730, 1, 1, 0);
        repeat (3) step("held_thru_rst", 1, 1, 16'h0730, 1, 1, 1);
        step("rel6", 1, 1, 16'h0730, 0, 0, 0);
        // random
        cur = 16'h0729; en = 1; stp = 0; snz = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) cur = times[$urandom_range(0, 2)];
            en = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 14) == 0) stp = ~stp;
            if ($urandom_range(0, 9) == 0) snz = ~snz;
            tk = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 399) != 0);
            step("random", rs, en, cur, stp, snz, tk);
        end
        @(posedge clk);
        #3;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
